// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, carry held between digits.
// Optional signed-overflow output enabled with `define SERIAL_ADDER_OVF_EN.
module serial_digit_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_co;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT:0]   w_sum;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_a_dig  = r_a[r_cnt*DIGIT +: DIGIT];
    assign w_b_dig  = r_b[r_cnt*DIGIT +: DIGIT];
    assign w_sum    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_c};

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    logic w_cin_msb;
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign w_cin_msb = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_sum[DIGIT-1];
    assign ovf       = r_ovf;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= sub ? ~b : b;
                r_c   <= sub ? ~ci : ci;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_s[r_cnt*DIGIT +: DIGIT] <= w_sum[DIGIT-1:0];
                r_c                       <= w_sum[DIGIT];
                if (w_last) begin
                    r_co <= w_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                    r_ovf <= w_cin_msb ^ w_sum[DIGIT];
`endif
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: if (start) w_next_state = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign s  = r_s;
    assign co = r_co;

endmodule
